instr_fetch_unit: RTL
=====================

Name:
instr_fetch_unit

Overview:
- Upstream neighbour of the control_unit FSM. Owns the PC, fetches 32-bit instructions from the instruction memory (BRAM, variable read latency) and decodes fixed fields for the control unit and datapath.
- Control unit strobes pc_update; this block selects the next PC (sequential, branch, jump, return), issues the memory read, and presents the held instruction with instr_valid.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; the first fetch uses it without increment.
- TIMEOUT_CYC, 16, maximum wait for imem_rvalid. Only used with IMEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- pc_update  in  1  one-cycle strobe from control unit: advance PC and fetch
- halt_pc  in  1  level; while high, pc_update is ignored and PC/instr are frozen
- jump  in  1  select jump target on this update
- branch_taken  in  1  select branch target on this update (datapath-resolved)
- ret_pc  in  1  select ret_addr on this update
- ret_addr  in  32  return address from stack/memory
- imem_addr  out  32  word-aligned read address
- imem_rd_en  out  1  one-cycle read request
- imem_rdata  in  32  read data
- imem_rvalid  in  1  read data valid, 1 cycle, 1..N cycles after imem_rd_en
- pc  out  32  address of the held instruction
- pc_plus4  out  32  pc + 4
- instr  out  32  held instruction
- opcode  out  6  instr[31:26]
- rs, rt, rd, shamt  out  5 each  instr[25:21], [20:16], [15:11], [10:6]
- funct  out  6  instr[5:0]
- imm16  out  16  instr[15:0]
- instr_valid  out  1  instr/pc are stable and correspond to the latest fetch
- fetch_err  out  1  sticky error flag; only driven with IMEM_TIMEOUT_EN, else tied 0

Behaviour:
- Reset, asynchronous. State IDLE. pc=RESET_PC, first_fetch=1, instr=32'h0, instr_valid=0, imem_rd_en=0, imem_addr=RESET_PC, fetch_err=0.
- States:
  - IDLE: waits for the first pc_update.
  - REQ: imem_rd_en=1 for exactly one cycle with imem_addr=pc.
  - WAIT: waits for imem_rvalid.
  - HOLD: instr_valid=1.
- IDLE/HOLD with pc_update=1 and halt_pc=0:
  - PC select priority: first_fetch (pc stays RESET_PC) > ret_pc > jump > branch_taken > sequential.
    - ret_pc: ret_addr with bits[1:0] forced to 0.
    - jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
    - branch_taken: pc_plus4 + (sign-extended imm16 << 2), modulo 2^32.
    - sequential: pc_plus4.
  - Capture the new pc, clear first_fetch and instr_valid, then go to REQ.
- Target computation always uses the currently held instr. Selects are sampled only in the pc_update cycle.
- REQ→WAIT next cycle. If imem_rvalid is already high in the REQ cycle, ignore it; responses are only accepted in WAIT.
- WAIT with imem_rvalid=1: instr<=imem_rdata, go to HOLD. instr_valid rises the cycle after rvalid.
- Minimum latency is 3 cycles from pc_update to instr_valid (pc_update → REQ → WAIT+rvalid → HOLD).
- pc_update in REQ/WAIT is ignored; the control unit must not issue it. No queuing.
- halt_pc=1 in HOLD: outputs frozen indefinitely. Releasing halt does not trigger a fetch; a new pc_update is required.
- halt_pc asserted in REQ/WAIT: the in-flight fetch completes to HOLD, then freezes.
- Decoded field outputs are combinational slices of the instr register.
- pc_plus4 wraps 32'hFFFF_FFFC→0.

Optional Feature:
- Macro IMEM_TIMEOUT_EN.
  - Defined: a counter runs in WAIT. If TIMEOUT_CYC cycles pass without imem_rvalid:
    - instr<=32'h0000_0000 (NOP);
    - fetch_err<=1 (sticky until rst);
    - go to HOLD with instr_valid=1.
  - A late rvalid arriving in HOLD is discarded.
  - Not defined: WAIT is unbounded, no counter exists, fetch_err=0.

Decomposition:
- Package coa_cpu_pkg:
  - opcode/funct localparams (R-type 6'b000000 etc.);
  - fetch state encoding (IDLE, REQ, WAIT, HOLD);
  - NOP_INSTR constant;
  - instruction field bit-position constants.
- One combinational sub-module, next_pc_sel: inputs pc_plus4, instr, ret_addr and the selects plus first_fetch; output next_pc.

Test Plan:
- rst, then pc_update, with imem latency 1 returning 32'h0022_1820 → imem_addr=0; instr_valid 3 cycles after pc_update; opcode=0, rs=1, rt=2, rd=3, funct=6'h20; pc=0.
- Second sequential pc_update → imem_addr=4, pc=4, pc_plus4=8.
- At pc=8, instr imm16=16'hFFFE, branch_taken=1 → pc=8+4-8=4. Then jump with instr[25:0]=26'h40 → pc=32'h100.
- ret_pc=1 and jump=1 together, ret_addr=32'h203 → pc=32'h200 (ret wins, low bits masked).
- halt_pc=1 during HOLD, pc_update pulsed 5 times → imem_rd_en never asserts, pc/instr unchanged. Release halt, pulse once → exactly one fetch.
- IMEM_TIMEOUT_EN, TIMEOUT_CYC=4, rvalid withheld → after 4 WAIT cycles instr=0, fetch_err=1, instr_valid=1. Assert rst mid-WAIT → immediate return to IDLE, pc=RESET_PC, fetch_err=0.

Source files
------------

// File: rtl/coa_cpu_pkg.sv
// Shared CPU definitions: opcode/funct encodings, fetch FSM state
// encoding, the NOP instruction word and instruction field positions.
package coa_cpu_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2,
    FETCH_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Instruction field bit positions
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

endpackage

// File: rtl/instr_fetch_unit_next_pc_sel.sv
// next_pc_sel: combinational next-PC mux for the fetch unit.
// Ports:
//   first_fetch  - first fetch after reset, PC stays at RESET_PC
//   ret_pc/jump/branch_taken - target selects, priority in that order
//   pc_plus4     - address following the held instruction
//   instr        - currently held instruction (jump index / branch offset)
//   ret_addr     - return address, low two bits are dropped
//   next_pc      - selected fetch address
module next_pc_sel #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        first_fetch,
  input  logic        ret_pc,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic [31:0] ret_addr,
  output logic [31:0] next_pc
);

  logic [31:0] jump_tgt;
  logic [31:0] branch_tgt;

  // Masking keeps the whole vectors in use while picking only the
  // relevant bits (index field, upper PC nibble).
  assign jump_tgt   = (pc_plus4 & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
  assign branch_tgt = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (first_fetch)       next_pc = RESET_PC;
    else if (ret_pc)       next_pc = ret_addr & ~32'h3;
    else if (jump)         next_pc = jump_tgt;
    else if (branch_taken) next_pc = branch_tgt;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches one instruction per pc_update
// strobe from a variable-latency instruction memory and presents the held
// instruction plus its decoded fields.
// Ports:
//   clk, rst                 - clock, async active-high reset
//   pc_update, halt_pc       - fetch strobe and freeze level
//   jump, branch_taken, ret_pc, ret_addr - next-PC selection
//   imem_addr/imem_rd_en     - one-cycle read request
//   imem_rdata/imem_rvalid   - read response (accepted only in WAIT)
//   pc, pc_plus4, instr, decoded fields, instr_valid - held instruction
//   fetch_err                - sticky timeout flag
// Optional: define IMEM_TIMEOUT_EN to bound the WAIT state to TIMEOUT_CYC
// cycles; on expiry a NOP is held and fetch_err is set.
module instr_fetch_unit
  import coa_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_update,
  input  logic        halt_pc,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic        ret_pc,
  input  logic [31:0] ret_addr,
  output logic [31:0] imem_addr,
  output logic        imem_rd_en,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic        instr_valid,
  output logic        fetch_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         first_fetch_q, first_fetch_d;
  logic [31:0]  next_pc;

`ifdef IMEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  assign pc_plus4 = pc_q + 32'd4;

  next_pc_sel #(.RESET_PC(RESET_PC)) u_next_pc_sel (
    .first_fetch  (first_fetch_q),
    .ret_pc       (ret_pc),
    .jump         (jump),
    .branch_taken (branch_taken),
    .pc_plus4     (pc_plus4),
    .instr        (instr_q),
    .ret_addr     (ret_addr),
    .next_pc      (next_pc)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    first_fetch_d = first_fetch_q;
`ifdef IMEM_TIMEOUT_EN
    cnt_d         = cnt_q;
    err_d         = err_q;
`endif
    case (state_q)
      FETCH_IDLE, FETCH_HOLD: begin
        if (pc_update && !halt_pc) begin
          pc_d          = next_pc;
          first_fetch_d = 1'b0;
          state_d       = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        // Any rvalid seen here belongs to nothing we asked for yet.
        state_d = FETCH_WAIT;
`ifdef IMEM_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      FETCH_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = FETCH_HOLD;
        end
`ifdef IMEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          instr_d = NOP_INSTR;
          err_d   = 1'b1;
          state_d = FETCH_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FETCH_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0;
      first_fetch_q <= 1'b1;
`ifdef IMEM_TIMEOUT_EN
      cnt_q         <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      first_fetch_q <= first_fetch_d;
`ifdef IMEM_TIMEOUT_EN
      cnt_q         <= cnt_d;
      err_q         <= err_d;
`endif
    end
  end

`ifdef IMEM_TIMEOUT_EN
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  assign imem_addr   = pc_q;
  assign imem_rd_en  = (state_q == FETCH_REQ);
  assign instr_valid = (state_q == FETCH_HOLD);
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign rs          = instr_q[RS_MSB:RS_LSB];
  assign rt          = instr_q[RT_MSB:RT_LSB];
  assign rd          = instr_q[RD_MSB:RD_LSB];
  assign shamt       = instr_q[SHAMT_MSB:SHAMT_LSB];
  assign funct       = instr_q[FUNCT_MSB:FUNCT_LSB];
  assign imm16       = instr_q[IMM_MSB:IMM_LSB];

endmodule
